// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, the NOP word, and the opcode map
// that the control FSM also decodes against.
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Wait-state counter for the fetch stage; expired fires on the LIMIT-th consecutive enabled cycle.
module fetch_timeout_ctr #(
    parameter int unsigned LIMIT = 15
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count;

    // The count never needs to pass LIMIT-1; the expiring cycle itself is the LIMIT-th.
    assign expired = en && (count == CNT_W'(LIMIT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, runs the req/ack handshake with instruction memory.
// Optional wait-state abort is compiled in with `define FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned          PC_W        = 64,
    parameter logic [PC_W-1:0]      RESET_PC    = '0,
    parameter int unsigned          TIMEOUT_CYC = 15
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            fetch_req,
    input  logic            pc_wr,
    input  logic [PC_W-1:0] pc_wr_data,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_ack,
    output logic [PC_W-1:0] PC,
    output logic [31:0]     INSTRUCAO,
    output logic [6:0]      op_code,
    output logic            instr_valid,
    output logic            busy,
    output logic            misalign,
    output logic            fetch_err
);

    fetch_state_e    state;
    logic [PC_W-1:0] eff_addr;
    logic            tmo_expired;

    // A same-cycle PC write is bypassed so a branch target can be fetched immediately.
    assign eff_addr = pc_wr ? pc_wr_data : PC;
    assign op_code  = INSTRUCAO[6:0];
    assign busy     = (state != ST_IDLE);

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (state != ST_WAIT),
        .en      ((state == ST_WAIT) && !mem_ack),
        .expired (tmo_expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_err <= 1'b0;
        end else if (tmo_expired) begin
            fetch_err <= 1'b1;
        end
    end
`else
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
    assign tmo_expired = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            PC          <= RESET_PC;
            INSTRUCAO   <= 32'h0;
            mem_addr    <= '0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
            if (pc_wr) begin
                PC <= pc_wr_data;
            end
            case (state)
                ST_IDLE: begin
                    if (fetch_req) begin
                        if (eff_addr[1:0] != 2'b00) begin
                            misalign <= 1'b1;
                        end else begin
                            mem_addr <= eff_addr;
                            mem_req  <= 1'b1;
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // A late ack on the expiry cycle still wins over the abort.
                    if (mem_ack) begin
                        INSTRUCAO   <= mem_rdata;
                        mem_req     <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_DONE;
                    end else if (tmo_expired) begin
                        INSTRUCAO   <= NOP_INSTR;
                        mem_req     <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage feeding the multicycle control FSM and datapath. Owns the PC and the instruction register (IR), and runs a req/ack handshake with instruction memory that may insert wait states. Exposes the latched instruction word and its opcode field to the control FSM. Accepts PC writes from the control path, covering sequential increment and branch targets.

Parameters:
PC_W, 64, PC and memory address width
RESET_PC, 64'h0, PC value after reset
TIMEOUT_CYC, 15, max wait cycles before fetch abort (only with FETCH_TIMEOUT_EN)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
fetch_req  in  1  one-cycle pulse from control FSM: fetch at current PC
pc_wr  in  1  load PC from pc_wr_data at next edge
pc_wr_data  in  PC_W  new PC value
mem_req  out  1  instruction memory request, held until ack
mem_addr  out  PC_W  registered fetch address
mem_rdata  in  32  instruction word, valid when mem_ack=1
mem_ack  in  1  memory completion, one cycle
PC  out  PC_W  current program counter
INSTRUCAO  out  32  instruction register contents
op_code  out  7  INSTRUCAO[6:0], combinational from IR
instr_valid  out  1  one-cycle pulse: IR updated this cycle
busy  out  1  high in any state other than IDLE
misalign  out  1  one-cycle pulse: fetch refused, PC[1:0]!=0
fetch_err  out  1  sticky timeout error (FETCH_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (async, any state, including mid-fetch):
  - PC=RESET_PC, IR=32'h0, mem_addr=0, mem_req=0.
  - instr_valid=0, misalign=0, fetch_err=0, state=IDLE.
  - An in-flight memory transaction is abandoned. A mem_ack arriving after reset release is ignored because the state is IDLE.
- States: IDLE, WAIT, DONE.
- IDLE, on fetch_req:
  - Effective address = pc_wr ? pc_wr_data : PC. pc_wr has priority and is bypassed into the fetch.
  - If effective address [1:0]!=0: pulse misalign next cycle, stay IDLE, no mem_req, IR unchanged.
  - Otherwise: mem_addr<=effective address, mem_req<=1, go WAIT.
- WAIT:
  - mem_req stays 1 and mem_addr stays stable until mem_ack.
  - On mem_ack: IR<=mem_rdata, mem_req<=0, go DONE.
  - mem_ack in the same cycle the request is issued cannot occur, since mem_req is registered. Minimum fetch latency is 2 cycles from fetch_req to instr_valid.
- DONE: instr_valid=1 for exactly one cycle, then IDLE. IR holds until the next successful fetch.
- fetch_req while busy=1: ignored, no queuing.
- pc_wr accepted in every state and updates PC at the next edge. During WAIT it does not change mem_addr; the current fetch completes at the old address.
- mem_ack in IDLE or DONE: ignored.
- PC arithmetic is done externally. The block only stores the value; no wrap checks.
- Outputs mem_req, mem_addr, instr_valid and misalign are registered; op_code and busy are combinational.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without mem_ack.
  - When the count reaches TIMEOUT_CYC: mem_req<=0, IR<=32'h00000013 (NOP), fetch_err<=1 (sticky until RST), go DONE. instr_valid still pulses so the control FSM never hangs.
  - mem_ack in the same cycle as expiry wins: normal load, no error.
- Undefined: no counter; WAIT is unbounded; fetch_err tied 0.

Decomposition:
- Package riscv_fetch_pkg:
  - state enum typedef (IDLE/WAIT/DONE).
  - NOP_INSTR=32'h00000013.
  - opcode localparams (OP_R=7'b0110011, OP_I=7'b0010011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011, OP_LUI=7'b0110111, OP_JAL=7'b1101111), shared with the control FSM.
- Sub-module fetch_timeout_ctr: a small counter with clear/enable/expired, instantiated only under FETCH_TIMEOUT_EN. Everything else stays in one module.

Test Plan:
- Reset then fetch_req with PC=0, mem_ack 3 cycles later with rdata=32'h00500093 -> mem_addr=0, mem_req high 3 cycles, INSTRUCAO=32'h00500093, op_code=7'b0010011, instr_valid one pulse.
- fetch_req and pc_wr together in IDLE, pc_wr_data=64'h40 -> mem_addr=64'h40, PC=64'h40.
- pc_wr=64'h80 during WAIT at address 0x10 -> mem_addr stays 0x10 until ack, PC=64'h80 afterward; second fetch_req during WAIT is ignored.
- pc_wr_data=64'h6 then fetch_req -> misalign pulses, mem_req never asserts, IR unchanged, busy stays 0.
- RST asserted in WAIT, then mem_ack one cycle after release -> all outputs at reset values, IR=0, no instr_valid.
- FETCH_TIMEOUT_EN, TIMEOUT_CYC=15, no ack -> after 15 WAIT cycles mem_req=0, INSTRUCAO=32'h00000013, instr_valid pulse, fetch_err=1 until RST.
